data_sram_bridge: RTL and testbench

Data-side memory interlayer: the responder for the MA stage's memory-access pulses (`MA_mem_read`/`MA_mem_write`). It buffers up to two requests in a FIFO and replays them in order on an SRAM-like handshake bus (`addr_ok`/`data_ok`). It drives `interlayer_ready` back to MA and returns load data toward WB. It sits between the MA stage and the data-side bus/cache port.

---
 rtl/data_sram_bridge.sv | 88 ++++++++
 tb/tb_data_sram_bridge.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: two-entry request FIFO replayed in order onto an SRAM-like addr_ok/data_ok bus
module data_sram_bridge (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        MA_mem_read,
  input  logic        MA_mem_write,
  input  logic [3:0]  MA_mem_wstrb,
  input  logic [31:0] MA_mem_addr,
  input  logic [31:0] MA_mem_wdata,
  output logic        interlayer_ready,
  output logic        mem_rdata_valid,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  logic [1:0] count;
  logic wp, rp, pend_wr, push, pop;
  logic [1:0] wr_q;
  logic [1:0][3:0] wstrb_q;
  logic [1:0][31:0] addr_q, wdata_q;
  assign interlayer_ready = count != 2'd2;
  assign push = (MA_mem_read | MA_mem_write) & interlayer_ready;
  assign data_req = (state == S_IDLE) && (count != 2'd0);
  assign pop = data_req & data_addr_ok;
  assign data_wr = wr_q[rp];
  assign data_wstrb = wstrb_q[rp];
  assign data_addr = addr_q[rp];
  assign data_wdata = wdata_q[rp];
  assign busy = (count != 2'd0) || (state == S_WAIT);
  // FIFO storage; reads carry a zero strobe so the bus shows 0000 for loads
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      wr_q <= '0;
      wstrb_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else if (push) begin
      wr_q[wp] <= MA_mem_write;
      wstrb_q[wp] <= MA_mem_write ? MA_mem_wstrb : 4'b0;
      addr_q[wp] <= MA_mem_addr;
      wdata_q[wp] <= MA_mem_wdata;
    end
  end
  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      wp <= push ? ~wp : wp;
      rp <= pop ? ~rp : rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  // Single-outstanding bus FSM; load responses are registered, write responses dropped
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state <= S_IDLE;
      pend_wr <= 1'b0;
      mem_rdata <= 32'd0;
      mem_rdata_valid <= 1'b0;
    end else begin
      mem_rdata_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (pop) begin
          pend_wr <= data_wr;
          state <= S_WAIT;
        end
      end else if (data_data_ok) begin
        state <= S_IDLE;
        if (!pend_wr) begin
          mem_rdata <= data_rdata;
          mem_rdata_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge: directed scenario tests for data_sram_bridge
module tb_data_sram_bridge;
  logic clk = 1'b0, rst_p = 1'b1;
  logic MA_mem_read = 1'b0, MA_mem_write = 1'b0;
  logic [3:0] MA_mem_wstrb = 4'd0;
  logic [31:0] MA_mem_addr = 32'd0, MA_mem_wdata = 32'd0;
  logic interlayer_ready, mem_rdata_valid, busy, data_req, data_wr;
  logic [31:0] mem_rdata, data_addr, data_wdata;
  logic [3:0] data_wstrb;
  logic data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;
  int passed = 0, total = 0;

  data_sram_bridge dut (
    .clk(clk), .rst_p(rst_p),
    .MA_mem_read(MA_mem_read), .MA_mem_write(MA_mem_write), .MA_mem_wstrb(MA_mem_wstrb),
    .MA_mem_addr(MA_mem_addr), .MA_mem_wdata(MA_mem_wdata),
    .interlayer_ready(interlayer_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .busy(busy), .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_p = 1'b1;
    tick();
    tick();
    total++; if ({interlayer_ready, data_req, data_wr, data_wstrb} !== 7'b1000000) $display("FAIL rst_ctrl got %b want 1000000", {interlayer_ready, data_req, data_wr, data_wstrb}); else passed++;
    total++; if ({data_addr, data_wdata, mem_rdata} !== 96'd0) $display("FAIL rst_data got %h want 0", {data_addr, data_wdata, mem_rdata}); else passed++;
    total++; if ({mem_rdata_valid, busy} !== 2'b00) $display("FAIL rst_status got %b want 00", {mem_rdata_valid, busy}); else passed++;
    rst_p = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({interlayer_ready, data_req, busy} !== 3'b100) $display("FAIL idle[%0d] got %b want 100", i, {interlayer_ready, data_req, busy}); else passed++;
    end
  endtask

  task automatic test_single_load;
    MA_mem_read = 1'b1; MA_mem_addr = 32'h1000_0040;
    tick();
    MA_mem_read = 1'b0;
    total++; if ({data_req, data_wr, data_wstrb, data_addr} !== {2'b10, 4'b0, 32'h1000_0040}) $display("FAIL load_bus got %b %h want 10 10000040", {data_req, data_wr, data_wstrb}, data_addr); else passed++;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    total++; if ({data_req, busy, mem_rdata_valid} !== 3'b010) $display("FAIL load_wait got %b want 010", {data_req, busy, mem_rdata_valid}); else passed++;
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    total++; if ({mem_rdata_valid, mem_rdata} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL load_resp got %b %h want 1 deadbeef", mem_rdata_valid, mem_rdata); else passed++;
    tick();
    total++; if ({mem_rdata_valid, busy, mem_rdata} !== {2'b00, 32'hDEAD_BEEF}) $display("FAIL load_after got %b %h want 00 deadbeef", {mem_rdata_valid, busy}, mem_rdata); else passed++;
  endtask

  task automatic test_store_waits;
    MA_mem_write = 1'b1; MA_mem_addr = 32'h0000_0008; MA_mem_wstrb = 4'b0011; MA_mem_wdata = 32'h0000_1234;
    tick();
    MA_mem_write = 1'b0; MA_mem_addr = 32'hFFFF_FFFC; MA_mem_wstrb = 4'b1111; MA_mem_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      total++; if ({data_req, data_wr, data_wstrb, data_addr, data_wdata} !== {2'b11, 4'b0011, 32'h8, 32'h1234}) $display("FAIL store_bus[%0d] got %b %h %h want 110011 8 1234", i, {data_req, data_wr, data_wstrb}, data_addr, data_wdata); else passed++;
      tick();
    end
    data_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if ({data_req, busy, mem_rdata_valid} !== 3'b010) $display("FAIL store_wait[%0d] got %b want 010", i, {data_req, busy, mem_rdata_valid}); else passed++;
      tick();
    end
    data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    total++; if ({busy, mem_rdata_valid, mem_rdata} !== {2'b00, 32'hDEAD_BEEF}) $display("FAIL store_done got %b %h want 00 deadbeef", {busy, mem_rdata_valid}, mem_rdata); else passed++;
  endtask

  task automatic test_fifo_full;
    MA_mem_write = 1'b1; MA_mem_addr = 32'h20; MA_mem_wstrb = 4'b1111; MA_mem_wdata = 32'hAAAA_5555;
    tick();
    MA_mem_write = 1'b0; MA_mem_read = 1'b1; MA_mem_addr = 32'h24; MA_mem_wdata = 32'd0;
    total++; if (interlayer_ready !== 1'b1) $display("FAIL full_one_ready got %b want 1", interlayer_ready); else passed++;
    tick();
    MA_mem_addr = 32'h28;
    total++; if (interlayer_ready !== 1'b0) $display("FAIL full_ready got %b want 0", interlayer_ready); else passed++;
    tick();
    MA_mem_read = 1'b0;
    total++; if ({interlayer_ready, data_req, data_wr, data_addr, data_wdata} !== {3'b011, 32'h20, 32'hAAAA_5555}) $display("FAIL full_headA got %b %h %h want 011 20 aaaa5555", {interlayer_ready, data_req, data_wr}, data_addr, data_wdata); else passed++;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    total++; if ({interlayer_ready, data_req} !== 2'b10) $display("FAIL full_reopen got %b want 10", {interlayer_ready, data_req}); else passed++;
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    total++; if ({data_req, data_wr, data_wstrb, data_addr, mem_rdata_valid} !== {2'b10, 4'b0, 32'h24, 1'b0}) $display("FAIL full_headB got %b %h %b want 100000 24 0", {data_req, data_wr, data_wstrb}, data_addr, mem_rdata_valid); else passed++;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBBBB_0001;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    total++; if ({mem_rdata_valid, mem_rdata, busy, data_req} !== {1'b1, 32'hBBBB_0001, 2'b00}) $display("FAIL full_respB got %b %h %b want 1 bbbb0001 00", mem_rdata_valid, mem_rdata, {busy, data_req}); else passed++;
    tick();
    total++; if (mem_rdata_valid !== 1'b0) $display("FAIL full_pulse got %b want 0", mem_rdata_valid); else passed++;
  endtask

  task automatic test_push_pop;
    MA_mem_read = 1'b1; MA_mem_addr = 32'h100;
    tick();
    MA_mem_read = 1'b0; MA_mem_write = 1'b1; MA_mem_addr = 32'h104; MA_mem_wstrb = 4'b0100; MA_mem_wdata = 32'h1111;
    data_addr_ok = 1'b1;
    total++; if ({data_req, data_wr, data_addr} !== {2'b10, 32'h100}) $display("FAIL pp_headX got %b %h want 10 100", {data_req, data_wr}, data_addr); else passed++;
    tick();
    MA_mem_write = 1'b0; data_addr_ok = 1'b0;
    total++; if ({interlayer_ready, busy, data_req} !== 3'b110) $display("FAIL pp_wait got %b want 110", {interlayer_ready, busy, data_req}); else passed++;
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_0001;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    total++; if ({mem_rdata_valid, mem_rdata} !== {1'b1, 32'hCAFE_0001}) $display("FAIL pp_respX got %b %h want 1 cafe0001", mem_rdata_valid, mem_rdata); else passed++;
    total++; if ({interlayer_ready, data_req, data_wr, data_wstrb, data_addr, data_wdata} !== {3'b111, 4'b0100, 32'h104, 32'h1111}) $display("FAIL pp_headY got %b %h %h want 1110100 104 1111", {interlayer_ready, data_req, data_wr, data_wstrb}, data_addr, data_wdata); else passed++;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    total++; if ({busy, interlayer_ready, mem_rdata_valid, data_req} !== 4'b0100) $display("FAIL pp_done got %b want 0100", {busy, interlayer_ready, mem_rdata_valid, data_req}); else passed++;
  endtask

  task automatic test_reset_wait;
    MA_mem_read = 1'b1; MA_mem_addr = 32'h200;
    tick();
    MA_mem_read = 1'b0; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    total++; if ({busy, data_req} !== 2'b10) $display("FAIL rw_wait got %b want 10", {busy, data_req}); else passed++;
    rst_p = 1'b1;
    #1;
    total++; if ({busy, data_req, interlayer_ready, mem_rdata} !== {3'b001, 32'd0}) $display("FAIL rw_async got %b %h want 001 0", {busy, data_req, interlayer_ready}, mem_rdata); else passed++;
    tick();
    rst_p = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    total++; if ({mem_rdata_valid, busy, data_req, mem_rdata} !== {3'b000, 32'd0}) $display("FAIL rw_ignored got %b %h want 000 0", {mem_rdata_valid, busy, data_req}, mem_rdata); else passed++;
    tick();
    total++; if ({mem_rdata_valid, busy, interlayer_ready} !== 3'b001) $display("FAIL rw_idle got %b want 001", {mem_rdata_valid, busy, interlayer_ready}); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_waits();
    test_fifo_full();
    test_push_pop();
    test_reset_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
